// File: rtl/gb_bus_pkg.sv
// Shared bus-side constants and types for the Game Boy memory interface blocks.
// Covers the DMA register address, the OAM window, the DMA FSM states and the T-cycle encoding.
package gb_bus_pkg;

    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam int unsigned OAM_LEN      = 160;
    localparam logic [7:0]  OAM_LAST     = 8'(OAM_LEN - 1);
    localparam int unsigned START_DELAY  = 1;
    localparam int unsigned DELAY_W      = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        XFER  = 2'd2
    } dma_state_t;

    localparam logic [1:0] T1 = 2'd0;
    localparam logic [1:0] T2 = 2'd1;
    localparam logic [1:0] T3 = 2'd2;
    localparam logic [1:0] T4 = 2'd3;

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: copies 160 bytes from {src, 8'h00} into OAM, one byte per M-cycle,
// owning the memory address mux while the copy runs.
module oam_dma
    import gb_bus_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  t_cycle,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data,
    input  logic        cpu_wr,
    input  logic        cpu_rd,
    output logic [7:0]  reg_rdata,
    output logic        dma_active,
    output logic [15:0] dma_addr,
    output logic        dma_rd,
    input  logic [7:0]  dma_rdata,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        oam_wr
);

    dma_state_t           state_q, state_d;
    logic [7:0]           src_q, src_d;
    logic [7:0]           idx_q, idx_d;
    logic [DELAY_W-1:0]   delay_q, delay_d;
    logic                 active_q, active_d;
    logic                 rd_q, rd_d;
    logic                 wr_q, wr_d;
    logic [7:0]           oam_addr_q, oam_addr_d;
    logic [7:0]           wdata_q, wdata_d;

    logic                 m_end;
    logic                 trig;
    logic [7:0]           eff_src;

    assign m_end   = (t_cycle == T4);
    assign trig    = m_end && cpu_wr && (cpu_addr == DMA_REG_ADDR);
    // 0xE0-0xFF sources fold onto the WRAM echo so DMA never reads OAM/IO space.
    assign eff_src = (src_q >= 8'hE0) ? (src_q - 8'h20) : src_q;

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        idx_d      = idx_q;
        delay_d    = delay_q;
        active_d   = active_q;
        wr_d       = 1'b0;
        oam_addr_d = oam_addr_q;
        wdata_d    = wdata_q;

        case (state_q)
            START: begin
                if (m_end) begin
                    if (delay_q <= DELAY_W'(1)) begin
                        state_d  = XFER;
                        delay_d  = '0;
                        active_d = 1'b1;
                    end else begin
                        delay_d = delay_q - DELAY_W'(1);
                    end
                end
            end
            XFER: begin
                if (t_cycle == T3) begin
                    wdata_d    = dma_rdata;
                    oam_addr_d = idx_q;
                    wr_d       = 1'b1;
                end
                if (m_end) begin
                    if (idx_q == OAM_LAST) begin
                        state_d  = IDLE;
                        active_d = 1'b0;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
            default: ;
        endcase

        // A retrigger keeps whatever bus ownership is current, so an interrupted
        // transfer holds the bus straight through the new start delay.
        if (trig) begin
            src_d    = cpu_data;
            idx_d    = '0;
            delay_d  = DELAY_W'(START_DELAY);
            state_d  = START;
            active_d = active_q;
        end

        // Registered strobe: assumes t_cycle advances by one per clock, so the
        // next cycle is T1..T3 unless the current one is T3.
        rd_d = (state_d == XFER) && (t_cycle != T3);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            src_q      <= 8'hFF;
            idx_q      <= '0;
            delay_q    <= '0;
            active_q   <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            oam_addr_q <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            idx_q      <= idx_d;
            delay_q    <= delay_d;
            active_q   <= active_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            oam_addr_q <= oam_addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign dma_active = active_q;
    assign dma_rd     = rd_q;
    assign oam_wr     = wr_q;
    assign oam_addr   = oam_addr_q;
    assign oam_wdata  = wdata_q;
    // Address only presented while DMA owns the mux; reads as zero otherwise.
    assign dma_addr   = active_q ? {eff_src, idx_q} : 16'h0000;
    assign reg_rdata  = (cpu_rd && (cpu_addr == DMA_REG_ADDR)) ? src_q : 8'h00;

endmodule

// File: doc/oam_dma.md
# oam_dma

OAM DMA engine: the bus-master counterpart to the CPU's memory interface. It responds to a CPU write of the DMA register (0xFF46), takes over the memory address mux, and copies 160 bytes from `{src, 8'h00}` to OAM (0xFE00–0xFE9F), one byte per M-cycle. It sits beside the CPU top. It drives the DMA leg of the memory address mux via `dma_active`/`dma_addr`, and feeds an OAM write port.

## Interface
- `DMA_REG_ADDR`, 16'hFF46, CPU-visible trigger/readback register address
- `OAM_LEN`, 160, bytes per transfer
- `START_DELAY`, 1, M-cycles between trigger and first read
- `clk  in  1`  system clock; one edge per T-cycle
- `rst  in  1`  reset; asynchronous, active-low
- `t_cycle  in  2`  T-cycle index from the decoder (0=T1 … 3=T4)
- `cpu_addr  in  16`  CPU address bus
- `cpu_data  in  8`  CPU write data
- `cpu_wr  in  1`  CPU write strobe
- `cpu_rd  in  1`  CPU read strobe
- `reg_rdata  out  8`  readback of the DMA register; valid when `cpu_rd && cpu_addr==DMA_REG_ADDR`, else 0x00
- `dma_active  out  1`  drives `mem_ctrl_sel`; 1 = DMA owns the memory address
- `dma_addr  out  16`  source address to the memory mux
- `dma_rd  out  1`  memory read enable
- `dma_rdata  in  8`  memory read data
- `oam_addr  out  8`  OAM byte index, 0x00–0x9F
- `oam_wdata  out  8`  OAM write data
- `oam_wr  out  1`  OAM write strobe, one clock wide

## Operation
- Register write: sampled on the rising edge where `t_cycle==3 && cpu_wr && cpu_addr==DMA_REG_ADDR`.
  - Effects: `src <= cpu_data`, `idx <= 0`, `delay <= START_DELAY`, state → START.
- Source mapping: `eff_src = (src >= 8'hE0) ? src - 8'h20 : src`, covering the echo region. `dma_addr = {eff_src, idx}`.
- States:
  - IDLE: `dma_active=0`, `dma_rd=0`.
  - START: `dma_active=0`, counting M-cycles. At the `t_cycle==3` edge, decrement `delay`. When it reaches 0, go to XFER.
  - XFER: `dma_active=1`. Each M-cycle:
    - `dma_rd=1` for T1–T3.
    - Capture `dma_rdata` into `oam_wdata` at the `t_cycle==2` edge.
    - `oam_wr=1` and `oam_addr=idx` during T4 (`t_cycle==3`).
    - At the `t_cycle==3` edge: if `idx==OAM_LEN-1`, go to IDLE; else `idx <= idx+1`.
- Retrigger: a register write in START or XFER restarts from START with the new `src` and `idx=0`.
  - If a retrigger arrives during XFER, `dma_active` stays 1 through the new START, so the CPU never regains the bus mid-sequence.
  - The byte in flight in that M-cycle still completes its `oam_wr`.
- Trigger write and the last-byte transition on the same edge: the trigger wins, and state → START.
- `reg_rdata` returns the last written `src`. It is 0xFF after reset.
- `idx` never exceeds 0x9F and never wraps.

## Timing
- Reset values (async, on `rst==0`):
  - state=IDLE, `src=0xFF`, `idx=0`, `delay=0`.
  - `dma_active=0`, `dma_rd=0`, `oam_wr=0`, `oam_addr=0`, `oam_wdata=0`, `dma_addr=0`.
- Reset mid-transfer aborts immediately. No further `oam_wr` occurs.
- Trigger at the M-cycle N T4 edge:
  - M-cycle N+1 is the START delay.
  - The first OAM write occurs in N+2 T4.
  - The last write (0x9F) occurs in N+161 T4.
  - `dma_active` falls at the N+161 T4 edge.
- Total bus occupancy: 160 M-cycles. `oam_wr` pulses exactly 160 times per uninterrupted transfer.
- All outputs are registered except `reg_rdata` (combinational from `src`) and `dma_addr` (combinational from `eff_src`/`idx`).

## Structure
- Shared package `gb_bus_pkg`:
  - `DMA_REG_ADDR`, `OAM_BASE=16'hFE00`, `OAM_LEN`.
  - `dma_state_t` enum {IDLE, START, XFER}.
  - The `t_cycle` encodings T1–T4.
- Single module, no sub-module: state register, 8-bit index counter, small delay counter, data capture register.

## Test plan
- Reset, then read 0xFF46 → `reg_rdata=0xFF`, `dma_active=0`, no `oam_wr`.
- Write 0xC1 to 0xFF46, memory preloaded with `mem[0xC100+i]=i^0x5A` → 160 `oam_wr` pulses, `oam_addr` 0x00..0x9F, `oam_wdata=i^0x5A`; first write at trigger+2 M-cycles T4; `dma_active` high exactly 160 M-cycles.
- Write 0xFE → `dma_addr` sequence 0xDE00..0xDE9F (echo mapping).
- Retrigger 0xC2 at `idx=0x40` → byte 0x40 still written from 0xC140; then 0xC200.. after 1 M-cycle delay with `dma_active` held; total 65+160 writes.
- Deassert `rst` at `idx=0x10` → all outputs zero immediately; no further writes; a later trigger runs a full 160-byte transfer.
- Write to 0xFF47 or a read of 0xFF46 during IDLE → no state change, `dma_active` stays 0.
